// File: rtl/jk_bank_ctrl_if.sv
// Command, bank and response signals of the JK bank controller.
// The slave side is the controller; the master side is the host and the bank.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] rsp_q;

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_data, q,
    output cmd_ready, j, k, busy, done, err, rsp_q
  );

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_data, q,
    input  cmd_ready, j, k, busy, done, err, rsp_q
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops.
// Drives j/k for one cycle per step, then verifies q against the expectation.
module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic         clk,
  input logic         rst,
  jk_bank_ctrl_if.slave bus
);

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C1  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] e;
  } drv_t;

  function automatic drv_t drive(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] qv
  );
    drv_t r;
    logic run;
    r   = '0;
    r.e = qv;
    run = 1'b1;
    unique case (op)
      OP_HOLD: r.e = qv;
      OP_SET: begin
        r.j = m;
        r.e = qv | m;
      end
      OP_CLEAR: begin
        r.k = m;
        r.e = qv & ~m;
      end
      OP_TOGGLE: begin
        r.j = m;
        r.k = m;
        r.e = qv ^ m;
      end
      OP_LOAD: begin
        r.j = d & m;
        r.k = ~d & m;
        r.e = (qv & ~m) | (d & m);
      end
      OP_COUNT: begin
        // ripple-free counter: bit i toggles when all lower bits are 1
        for (int i = 0; i < WIDTH; i++) begin
          r.j[i] = run;
          r.k[i] = run;
          run    = run & qv[i];
        end
        r.e = qv + ONE;
      end
      default: r.e = qv;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             nodrv_q, nodrv_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rsp_r, rsp_d;

  drv_t acc_drv;
  drv_t step_drv;
  logic cmd_ill;
  logic cmd_nodrv;
  logic match;

  assign acc_drv  = drive(bus.cmd_op, bus.cmd_mask,
                          bus.cmd_data, bus.q);
  assign step_drv = drive(OP_COUNT, '0, '0, bus.q);
  assign cmd_ill  = bus.cmd_op[2] & bus.cmd_op[1];
  assign cmd_nodrv = cmd_ill |
    ((bus.cmd_op == OP_COUNT) &&
     (bus.cmd_data[CNT_W-1:0] == '0));
  assign match = (bus.q == exp_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    nodrv_d = nodrv_q;
    ill_d   = ill_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rsp_d   = rsp_r;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = APPLY;
          op_d    = bus.cmd_op;
          cnt_d   = bus.cmd_data[CNT_W-1:0];
          exp_d   = acc_drv.e;
          ill_d   = cmd_ill;
          nodrv_d = cmd_nodrv;
          if (!cmd_nodrv) begin
            j_d = acc_drv.j;
            k_d = acc_drv.k;
          end
        end
      end
      APPLY: begin
        if (nodrv_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = ill_q;
          rsp_d   = bus.q;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (match && op_q == OP_COUNT && cnt_q > C1) begin
          state_d = APPLY;
          cnt_d   = cnt_q - C1;
          exp_d   = step_drv.e;
          j_d     = step_drv.j;
          k_d     = step_drv.k;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = !match;
          rsp_d   = bus.q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      nodrv_q <= 1'b0;
      ill_q   <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rsp_r   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      nodrv_q <= nodrv_d;
      ill_q   <= ill_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_r   <= rsp_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) & rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rsp_q     = rsp_r;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: behavioural JK bank, vector table,
// completion scoreboard and hand-written corner sequences.
module tb_jk_bank_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(W)) bus ();

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;
  always @(posedge clk) bank <= (bus.j & ~bank) | (~bus.k & bank);
  assign bus.q = bank & ~stuck;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rsp;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] m;
    logic [W-1:0] d;
    logic [W-1:0] rsp;
    logic         e;
    int           lat;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: rsp_q %0h", bus.rsp_q);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_q", {24'd0, bus.rsp_q}, {24'd0, mon_e.rsp});
        chk("err", {31'd0, bus.err}, {31'd0, mon_e.e});
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (!bus.busy && (bus.j != '0 || bus.k != '0)) begin
      checks++;
      errors++;
      $display("FAIL jk_outside_apply: j %0h k %0h", bus.j, bus.k);
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] m,
                      input logic [W-1:0] d, input logic [W-1:0] rsp,
                      input logic e, input int lat,
                      output logic done_seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready %0b want 1", bus.cmd_ready);
    end
    done_seen     = bus.done;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = m;
    bus.cmd_data  = d;
    sb.push_back('{rsp, e, lat, cyc + 1});
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

  initial begin
    logic ds;
    tbl[0] = '{3'd2, 8'h05, 8'h00, 8'h50, 1'b0, 2};
    tbl[1] = '{3'd1, 8'h81, 8'h00, 8'hD1, 1'b0, 2};
    tbl[2] = '{3'd3, 8'hFF, 8'h00, 8'h2E, 1'b0, 2};
    tbl[3] = '{3'd4, 8'h0F, 8'h3C, 8'h2C, 1'b0, 2};
    tbl[4] = '{3'd0, 8'hFF, 8'hFF, 8'h2C, 1'b0, 2};
    tbl[5] = '{3'd4, 8'hF0, 8'h12, 8'h1C, 1'b0, 2};
    tbl[6] = '{3'd5, 8'hFF, 8'h02, 8'h1E, 1'b0, 4};
    tbl[7] = '{3'd7, 8'hFF, 8'h00, 8'h1E, 1'b1, 1};
    tbl[8] = '{3'd4, 8'hFF, 8'hFE, 8'hFE, 1'b0, 2};
    tbl[9] = '{3'd1, 8'h00, 8'h00, 8'hFE, 1'b0, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_mask  = '0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_rsp", {24'd0, bus.rsp_q}, 0);
    chk("rst_jk", {16'd0, bus.j, bus.k}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.cmd_ready}, 1);

    send(3'd1, 8'h0F, 8'h00, 8'h0F, 1'b0, 2, ds);
    chk("set_j", {24'd0, bus.j}, 32'h0F);
    chk("set_k", {24'd0, bus.k}, 32'h00);
    chk("set_busy", {31'd0, bus.busy}, 1);
    @(negedge clk);
    chk("set_j_cleared", {16'd0, bus.j, bus.k}, 0);
    wait_idle();

    send(3'd4, 8'hFF, 8'hA5, 8'hA5, 1'b0, 2, ds);
    send(3'd3, 8'hF0, 8'h00, 8'h55, 1'b0, 2, ds);
    chk("b2b_accept_on_done", {31'd0, ds}, 1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].m, tbl[i].d, tbl[i].rsp, tbl[i].e,
           tbl[i].lat, ds);
      wait_idle();
    end

    send(3'd5, 8'h00, 8'h03, 8'h01, 1'b0, 6, ds);
    chk("count_first_j", {24'd0, bus.j}, 32'h01);
    wait_idle();
    chk("count_wrap_q", {24'd0, bus.q}, 32'h01);

    send(3'd2, 8'hFF, 8'h00, 8'h00, 1'b0, 2, ds);
    wait_idle();
    stuck = 8'h01;
    send(3'd1, 8'h01, 8'h00, 8'h00, 1'b1, 2, ds);
    wait_idle();
    stuck = 8'h00;

    send(3'd6, 8'hFF, 8'hFF, 8'h01, 1'b1, 1, ds);
    chk("illegal_jk", {16'd0, bus.j, bus.k}, 0);
    wait_idle();
    send(3'd5, 8'hFF, 8'hF0, 8'h01, 1'b0, 1, ds);
    chk("count0_jk", {16'd0, bus.j, bus.k}, 0);
    wait_idle();

    send(3'd5, 8'h00, 8'h05, 8'h00, 1'b0, 10, ds);
    chk("count5_j", {24'd0, bus.j}, 32'h03);
    chk("count5_k", {24'd0, bus.k}, 32'h03);
    rst = 1'b0;
    #1;
    chk("midrst_jk", {16'd0, bus.j, bus.k}, 0);
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_done", {31'd0, bus.done}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.cmd_ready}, 1);
    chk("midrst_q_kept", {24'd0, bus.q}, 32'h01);
    send(3'd0, 8'hFF, 8'h00, 8'h01, 1'b0, 2, ds);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
